load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-wide Data_memory.
- Data_memory has no byte enables, so this block turns byte, halfword and word loads and stores into word-aligned memory cycles.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Misaligned and out-of-range accesses are rejected before any memory cycle is issued.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the attached Data_memory (2^ADDR_WIDTH bytes).
- DATA_WIDTH, 32, memory word width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted this cycle if req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; misaligned, illegal size or out of range.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_address  out  32  word-aligned byte address to Data_memory.
- mem_write_data  out  32  word to write.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_read_data  in  32  word from Data_memory.

Behaviour:
- Reset: state IDLE. req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_address=0; mem_write_data=0; mem_write=0; mem_read=0. All mem_* outputs decode from state, so they drop immediately on rst_n falling.
- States: IDLE, RD, CAP, WR, RESP. req_ready=1 only in IDLE.
- Accept: on a rising edge with req_valid && req_ready, latch all req_* fields. req_valid in any other state is ignored.
- Error at accept, with next state RESP, resp_err=1 and no memory cycle:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_addr >= 2^ADDR_WIDTH.
- Load path: IDLE -> RD -> CAP -> RESP.
  - RD and CAP: mem_read=1, mem_address={addr[31:2],2'b00}.
  - Word register captures mem_read_data at the CAP->RESP edge.
- Word store path: IDLE -> WR -> RESP.
  - WR: mem_write=1 for exactly one cycle, mem_write_data=req_wdata.
- Sub-word store path (byte/half): IDLE -> RD -> CAP -> WR -> RESP.
  - Merge into the captured word, little-endian.
  - Byte replaces lane k=addr[1:0], bits [8k+7:8k], with wdata[7:0].
  - Half replaces [15:0] if addr[1]=0, else [31:16], with wdata[15:0].
  - All other lanes are unchanged.
- Load extraction:
  - Byte lane k, or half per addr[1].
  - Sign-extended from bit 7 or 15 unless req_unsigned.
  - Word loads ignore req_unsigned.
- RESP:
  - resp_valid=1 for one cycle; next state IDLE.
  - resp_rdata and resp_err are registered and hold until the next RESP.
- Latency, counting cycles after the accept edge with resp_valid high in the last:
  - load: 3;
  - word store: 2;
  - sub-word store: 4;
  - error: 1.
  - Back-to-back issue is possible on the cycle after RESP.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_address[1:0] is always 00.
  - Exactly one mem_write pulse per accepted store; none for loads or errors.
- Reset mid-operation: return to IDLE asynchronously with no further memory cycles. If asserted during RD or CAP of a sub-word store, no write occurs and memory is unchanged. No resp_valid is issued for the aborted request.

Test Plan:
1. SW 0xAABBCCDD @0x4, then LW @0x4 -> exactly one mem_write pulse with mem_address=0x4; load resp_rdata=0xAABBCCDD, resp_err=0; resp_valid 2 and 3 cycles after accept respectively.
2. SB 0x80 @0x5, then LW @0x4 -> 0xAABB80DD; LB @0x5 -> 0xFFFFFF80; LBU @0x5 -> 0x00000080; the SB shows RD, CAP, WR order with a single write.
3. SH 0x1234 @0x6, then LW @0x4 -> 0x123480DD; LH @0x6 -> 0x00001234; SH 0x8000 @0x4, then LH @0x4 -> 0xFFFF8000.
4. LH @0x3; LW @0x6; req_size=11; LW @0x400 (ADDR_WIDTH=10) -> each gives resp_valid with resp_err=1 and resp_rdata=0, one cycle after accept; mem_read and mem_write stay 0 throughout.
5. SB 0x11 @0x4 with rst_n pulsed low during CAP, then LW @0x4 after release -> mem_write never asserted; reads the prior word (0x1234_8000 from scenario 3's final SH @0x4); resp_valid never pulses for the aborted SB.
6. req_valid held high with three queued loads -> req_ready is high only in IDLE; each request is accepted once; resp_valid pulses in order with no dropped or duplicated responses.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// Load/store unit: turns byte/half/word accesses into word-aligned cycles on a
// byte-enable-less Data_memory, using read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [31:0]           mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        accept, acc_err;
    logic [31:0] word_addr, merged, extracted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign accept  = req_valid && (state_q == IDLE);
    assign acc_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (|req_addr[31:ADDR_WIDTH]);
    assign word_addr = {addr_q[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
                if (acc_err)                          state_d = RESP;
                else if (req_we && req_size == 2'b10) state_d = WR;
                else                                  state_d = RD;
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load lane extraction straight from the memory word at the CAP edge
    always_comb begin
        byte_v = 8'(mem_read_data >> {addr_q[1:0], 3'b000});
        half_v = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   extracted = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   extracted = {{16{~uns_q & half_v[15]}}, half_v};
            default: extracted = mem_read_data;
        endcase
    end

    // Little-endian merge of store data into the captured word
    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                   else           merged[15:0]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (acc_err) begin
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= '0;
                end
            end
            if (state_q == CAP) begin
                word_q <= mem_read_data;
                if (!we_q) begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= extracted;
                end
            end
            if (state_q == WR) begin
                resp_err_q   <= 1'b0;
                resp_rdata_q <= '0;
            end
        end
    end

    // Outputs decode from state only, so they drop as soon as reset asserts
    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        resp_err       = resp_err_q;
        resp_rdata     = resp_rdata_q;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        case (state_q)
            RD, CAP: begin
                mem_read    = 1'b1;
                mem_address = word_addr;
            end
            WR: begin
                mem_write      = 1'b1;
                mem_address    = word_addr;
                mem_write_data = merged;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Directed bench for load_store_unit with a word memory model and a response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, mem_write, mem_read;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write),
        .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cnt = 0, wr_cnt = 0, issued = 0;
    logic [31:0] mem [0:255];

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_address[9:2]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (rst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Every response must match the oldest outstanding expectation, in the expected cycle
    always @(negedge clk) begin
        if (resp_valid) begin
            check("resp_expected", 32'(resp_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata,
                         input logic [31:0] wword, input logic hold);
        int   lat;
        exp_t e;
        logic exp_rd, exp_wr;
        lat = err ? 1 : (!we ? 3 : (sz == 2'b10 ? 2 : 4));
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        e.err = err; e.rdata = rdata; e.cyc = cyc + lat;
        sb.push_back(e);
        issued++;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            exp_rd = !err && (!we || sz != 2'b10) && i < 3;
            exp_wr = !err && we && ((sz == 2'b10 && i == 1) || (sz != 2'b10 && i == 3));
            check("req_ready_busy", 32'(req_ready), 32'd0);
            check("mem_read", 32'(mem_read), 32'(exp_rd));
            check("mem_write", 32'(mem_write), 32'(exp_wr));
            if (exp_rd || exp_wr) check("mem_address", mem_address, {addr[31:2], 2'b00});
            if (exp_wr) check("mem_write_data", mem_write_data, wword);
        end
    endtask

    int w0;

    initial begin
        // Reset state
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load
        w0 = wr_cnt;
        issue(1, 2'b10, 0, 32'h4, 32'hAABBCCDD, 0, 32'h0, 32'hAABBCCDD, 0);
        check("sw_one_write", 32'(wr_cnt - w0), 32'd1);
        issue(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'hAABBCCDD, 32'h0, 0);

        // Byte store, then word / signed / unsigned byte loads
        w0 = wr_cnt;
        issue(1, 2'b00, 0, 32'h5, 32'hFFFFFF80, 0, 32'h0, 32'hAABB80DD, 0);
        check("sb_one_write", 32'(wr_cnt - w0), 32'd1);
        issue(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'hAABB80DD, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h5, 32'h0, 0, 32'hFFFFFF80, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h5, 32'h0, 0, 32'h00000080, 32'h0, 0);

        // Halfword stores in both halves, then loads
        issue(1, 2'b01, 0, 32'h6, 32'h00001234, 0, 32'h0, 32'h123480DD, 0);
        issue(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h123480DD, 32'h0, 0);
        issue(0, 2'b01, 0, 32'h6, 32'h0, 0, 32'h00001234, 32'h0, 0);
        issue(1, 2'b01, 0, 32'h4, 32'hFFFF8000, 0, 32'h0, 32'h12348000, 0);
        issue(0, 2'b01, 0, 32'h4, 32'h0, 0, 32'hFFFF8000, 32'h0, 0);
        issue(0, 2'b01, 1, 32'h4, 32'h0, 0, 32'h00008000, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h7, 32'h0, 0, 32'h00000012, 32'h0, 0);
        issue(0, 2'b10, 1, 32'h4, 32'h0, 0, 32'h12348000, 32'h0, 0);

        // Rejected requests: no memory cycles, one-cycle error response
        w0 = wr_cnt;
        issue(0, 2'b01, 0, 32'h3,   32'h0, 1, 32'h0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h6,   32'h0, 1, 32'h0, 32'h0, 0);
        issue(0, 2'b11, 0, 32'h0,   32'h0, 1, 32'h0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h400, 32'h0, 1, 32'h0, 32'h0, 0);
        issue(1, 2'b10, 0, 32'h401, 32'h0, 1, 32'h0, 32'h0, 0);
        issue(1, 2'b00, 0, 32'h400, 32'h11, 1, 32'h0, 32'h0, 0);
        check("err_no_write", 32'(wr_cnt - w0), 32'd0);

        // Reset during CAP of a byte store aborts it with no write and no response
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h11;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_cap", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_read", 32'(mem_read), 32'd0);
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        issue(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h12348000, 32'h0, 0);

        // req_valid held high across three loads
        w0 = acc_cnt;
        issue(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h12348000, 32'h0, 1);
        issue(0, 2'b00, 0, 32'h5, 32'h0, 0, 32'hFFFFFF80, 32'h0, 1);
        issue(0, 2'b01, 0, 32'h6, 32'h0, 0, 32'h00001234, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        check("held_accepts", 32'(acc_cnt - w0), 32'd3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("accept_count", 32'(acc_cnt), 32'(issued + 1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
